// File: rtl/nd_2to1_arb_pkg.sv
// nd_2to1_arb_pkg: shared sizes, grant encoding and round-robin pick for the 2-to-1 merge node.
package nd_2to1_arb_pkg;

    localparam int NS_ADDRESS_SIZE = 6;
    localparam int NS_DATA_SIZE    = 32;
    localparam int NS_FIFO_SIZE    = 2;

    typedef enum logic {
        IN0 = 1'b0,
        IN1 = 1'b1
    } port_t;

    // A tie goes to the input that did not win last time.
    function automatic port_t pick(input logic ne0, input logic ne1, input port_t last);
        return (ne0 && ne1) ? ((last == IN0) ? IN1 : IN0) : (ne1 ? IN1 : IN0);
    endfunction

endpackage

// File: rtl/nd_msg_fifo.sv
// nd_msg_fifo: circular message buffer of 2^FSZ entries with occupancy counter.
module nd_msg_fifo
    import nd_2to1_arb_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int FSZ = NS_FIFO_SIZE
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [ASZ+DSZ-1:0] din,
    output logic [ASZ+DSZ-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam logic [FSZ:0] DEPTH = (FSZ+1)'(2**FSZ);

    logic [ASZ+DSZ-1:0] mem [2**FSZ];
    logic [FSZ-1:0]     head;
    logic [FSZ-1:0]     tail;
    logic [FSZ:0]       count;

    assign dout  = mem[head];
    assign full  = count == DEPTH;
    assign empty = count == '0;

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + FSZ'(1);
            if (pop) head <= head + FSZ'(1);
            if (push != pop) count <= push ? count + (FSZ+1)'(1) : count - (FSZ+1)'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (push) mem[tail] <= din;
    end

endmodule

// File: rtl/nd_2to1_arb.sv
// nd_2to1_arb: merges two 4-phase req/ack message channels into one,
// buffering each input and forwarding round-robin.
module nd_2to1_arb
    import nd_2to1_arb_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int FSZ = NS_FIFO_SIZE
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic           snd0_req,
    input  logic           snd0_ack,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic           rcv1_req,
    output logic           rcv1_ack
);

    logic               push0, push1, pop0, pop1;
    logic               full0, full1, empty0, empty1;
    logic               idle, any;
    logic [ASZ+DSZ-1:0] head0, head1;
    port_t              last_grant, grant;

    always_comb begin
        push0 = ready && rcv0_req && !rcv0_ack && !full0;
        push1 = ready && rcv1_req && !rcv1_ack && !full1;
        idle  = ready && !snd0_req && !snd0_ack;
        any   = !empty0 || !empty1;
        grant = pick(!empty0, !empty1, last_grant);
        pop0  = idle && any && grant == IN0;
        pop1  = idle && any && grant == IN1;
    end

    nd_msg_fifo #(.ASZ(ASZ), .DSZ(DSZ), .FSZ(FSZ)) u_fifo0 (
        .i_clk (i_clk),
        .reset (reset),
        .push  (push0),
        .pop   (pop0),
        .din   ({rcv0_dst, rcv0_dat}),
        .dout  (head0),
        .full  (full0),
        .empty (empty0)
    );

    nd_msg_fifo #(.ASZ(ASZ), .DSZ(DSZ), .FSZ(FSZ)) u_fifo1 (
        .i_clk (i_clk),
        .reset (reset),
        .push  (push1),
        .pop   (pop1),
        .din   ({rcv1_dst, rcv1_dat}),
        .dout  (head1),
        .full  (full1),
        .empty (empty1)
    );

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            ready      <= 1'b0;
            snd0_req   <= 1'b0;
            snd0_dst   <= '0;
            snd0_dat   <= '0;
            rcv0_ack   <= 1'b0;
            rcv1_ack   <= 1'b0;
            last_grant <= IN1;
        end else if (!ready) begin
            ready    <= 1'b1;
            snd0_req <= 1'b0;
            snd0_dst <= '0;
            snd0_dat <= '0;
            rcv0_ack <= 1'b0;
            rcv1_ack <= 1'b0;
        end else begin
            // Ack follows req down, and rises only with an accepted write.
            rcv0_ack <= rcv0_req && (rcv0_ack || push0);
            rcv1_ack <= rcv1_req && (rcv1_ack || push1);
            if (pop0 || pop1) begin
                {snd0_dst, snd0_dat} <= (grant == IN1) ? head1 : head0;
                snd0_req   <= 1'b1;
                last_grant <= grant;
            end else if (snd0_req && snd0_ack) begin
                snd0_req <= 1'b0;
            end
        end
    end

endmodule
